// File: rtl/retire_trace_serializer_pkg.sv
// Shared types for the retirement trace serializer: the retired-record payload
// and the widths it is built from.
package retire_trace_serializer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned TRACE_SEQ_W = 32;
    localparam int unsigned ISSUE_WIDTH = 2;
    localparam int unsigned LANE_W      = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        instr;
        logic [4:0]             rd;
        logic [XLEN-1:0]        rd_data;
        logic                   rd_we;
        logic [XLEN-1:0]        mem_addr;
        logic [XLEN-1:0]        mem_data;
        logic                   mem_wrt;
        logic [LANE_W-1:0]      lane;
        logic [TRACE_SEQ_W-1:0] seq;
    } retire_rec_t;

endpackage

// File: rtl/retire_trace_serializer_if.sv
// Per-lane retirement bus from the core: the core drives it (master), the
// serializer observes it (slave).
interface retire_trace_serializer_if
    import retire_trace_serializer_pkg::*;
#(
    parameter int unsigned IssueWidth = ISSUE_WIDTH
) ();

    logic [IssueWidth-1:0]           update_i;
    logic [IssueWidth-1:0][XLEN-1:0] pc_i;
    logic [IssueWidth-1:0][XLEN-1:0] instr_i;
    logic [IssueWidth-1:0][4:0]      reg_addr_i;
    logic [IssueWidth-1:0][XLEN-1:0] reg_data_i;
    logic [IssueWidth-1:0][XLEN-1:0] mem_addr_i;
    logic [IssueWidth-1:0][XLEN-1:0] mem_data_i;
    logic [IssueWidth-1:0]           mem_wrt_i;

    modport master (
        output update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
               mem_addr_i, mem_data_i, mem_wrt_i
    );

    modport slave (
        input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
               mem_addr_i, mem_data_i, mem_wrt_i
    );

endinterface

// File: rtl/retire_trace_serializer_rec_fifo.sv
// Multi-write / single-read record FIFO: up to IssueWidth compacted records are
// written per cycle starting at the write pointer, one record is read per pop.
module retire_rec_fifo
    import retire_trace_serializer_pkg::*;
#(
    parameter int unsigned IssueWidth = ISSUE_WIDTH,
    parameter int unsigned Depth      = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  retire_rec_t [IssueWidth-1:0]         wr_data_i,
    input  logic [$clog2(IssueWidth+1)-1:0]      wr_cnt_i,
    input  logic                                 pop_i,
    output retire_rec_t                          head_o,
    output logic                                 head_valid_o,
    output logic [$clog2(Depth+1)-1:0]           level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    retire_rec_t     r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [LvlW-1:0] r_level;
    logic            w_pop;

    // A pop request while empty is ignored.
    assign w_pop        = pop_i & (r_level != '0);
    assign head_valid_o = (r_level != '0);
    assign head_o       = head_valid_o ? r_mem[r_rd_ptr] : '0;
    assign level_o      = r_level;

    always_ff @(posedge clk_i or negedge rstn_i) begin : ptr_level
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PtrW'(wr_cnt_i);
            r_rd_ptr <= r_rd_ptr + PtrW'(w_pop);
            r_level  <= r_level + LvlW'(wr_cnt_i) - LvlW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin : storage
        for (int unsigned i = 0; i < IssueWidth; i++) begin
            if (i < 32'(wr_cnt_i)) begin
                r_mem[r_wr_ptr + PtrW'(i)] <= wr_data_i[i];
            end
        end
    end

endmodule

// File: rtl/retire_trace_serializer.sv
// Captures per-lane retirement records, compacts them in lane order with
// sequence numbers into a FIFO and streams them out one per cycle.
module retire_trace_serializer
    import retire_trace_serializer_pkg::*;
#(
    parameter int unsigned IssueWidth = ISSUE_WIDTH,
    parameter int unsigned Depth      = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    retire_trace_serializer_if.slave      rt,
    output logic                          rec_valid_o,
    input  logic                          rec_ready_i,
    output retire_rec_t                   rec_o,
    output logic [$clog2(Depth+1)-1:0]    level_o,
    output logic                          overflow_o,
    output logic [15:0]                   drop_cnt_o
);

    localparam int unsigned CntW = $clog2(IssueWidth+1);

    logic [IssueWidth-1:0]           w_lane_vld;
    logic [IssueWidth-1:0][CntW-1:0] w_rank;
    retire_rec_t [IssueWidth-1:0]    w_lane_rec;
    retire_rec_t [IssueWidth-1:0]    w_cmp;
    logic [CntW-1:0]                 w_n;
    logic [CntW-1:0]                 w_wr_cnt;
    logic                            w_accept;
    logic                            w_pop;
    logic [16:0]                     w_drop_sum;

    logic [TRACE_SEQ_W-1:0]          r_seq;
    logic                            r_overflow;
    logic [15:0]                     r_drop_cnt;

    assign w_lane_vld = rt.update_i | rt.mem_wrt_i;

    // Build masked per-lane records and rank each valid lane among the valid ones.
    always_comb begin : lane_build
        w_n        = '0;
        w_rank     = '0;
        w_lane_rec = '0;
        for (int k = 0; k < IssueWidth; k++) begin
            w_rank[k]           = w_n;
            w_lane_rec[k].pc    = rt.pc_i[k];
            w_lane_rec[k].instr = rt.instr_i[k];
            if (rt.update_i[k]) begin
                w_lane_rec[k].rd      = rt.reg_addr_i[k];
                w_lane_rec[k].rd_data = rt.reg_data_i[k];
                w_lane_rec[k].rd_we   = 1'b1;
            end
            if (rt.mem_wrt_i[k]) begin
                w_lane_rec[k].mem_addr = rt.mem_addr_i[k];
                w_lane_rec[k].mem_data = rt.mem_data_i[k];
                w_lane_rec[k].mem_wrt  = 1'b1;
            end
            w_lane_rec[k].lane = LANE_W'(k);
            w_lane_rec[k].seq  = r_seq + TRACE_SEQ_W'(w_n);
            if (w_lane_vld[k]) begin
                w_n = w_n + CntW'(1);
            end
        end
    end

    // Compact valid lanes into consecutive write slots, lane 0 first.
    always_comb begin : compact
        w_cmp = '0;
        for (int j = 0; j < IssueWidth; j++) begin
            for (int k = 0; k < IssueWidth; k++) begin
                if (w_lane_vld[k] && (w_rank[k] == CntW'(j))) begin
                    w_cmp[j] = w_lane_rec[k];
                end
            end
        end
    end

    // All-or-nothing acceptance against the registered level; a same-cycle pop is not free space.
    assign w_accept   = (Depth - 32'(level_o)) >= 32'(w_n);
    assign w_wr_cnt   = w_accept ? w_n : '0;
    assign w_pop      = rec_valid_o & rec_ready_i;
    assign w_drop_sum = 17'(r_drop_cnt) + 17'(w_n);

    always_ff @(posedge clk_i or negedge rstn_i) begin : seq_drop
        if (!rstn_i) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_seq <= r_seq + TRACE_SEQ_W'(w_n);
            if (!w_accept) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end

    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

    retire_rec_fifo #(
        .IssueWidth (IssueWidth),
        .Depth      (Depth)
    ) u_fifo (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .wr_data_i    (w_cmp),
        .wr_cnt_i     (w_wr_cnt),
        .pop_i        (w_pop),
        .head_o       (rec_o),
        .head_valid_o (rec_valid_o),
        .level_o      (level_o)
    );

endmodule

// File: doc/retire_trace_serializer.md
Name: retire_trace_serializer

Overview:
- Consumer end of the core's dual-issue retirement interface (update/pc/instr/reg/mem per lane).
- Captures up to IssueWidth retirement records per cycle and compacts them in lane order into a FIFO.
- Emits one record per cycle over a valid/ready stream to the trace logger/checker.
- Flags overflow, because the core has no backpressure on retirement.

Parameters:
- IssueWidth, 2, number of retirement lanes.
- Depth, 8, FIFO entries; power of two, >= 2*IssueWidth.
- XLEN, riscv_pkg::XLEN, data/address width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset
- update_i  in  1 [IssueWidth]  lane register-write retire strobe
- pc_i  in  XLEN [IssueWidth]  retired PC
- instr_i  in  XLEN [IssueWidth]  retired instruction word
- reg_addr_i  in  5 [IssueWidth]  destination register
- reg_data_i  in  XLEN [IssueWidth]  writeback data
- mem_addr_i  in  XLEN [IssueWidth]  store address
- mem_data_i  in  XLEN [IssueWidth]  store data
- mem_wrt_i  in  1 [IssueWidth]  store strobe
- rec_valid_o  out  1  head record valid
- rec_ready_i  in  1  consumer accepts head
- rec_o  out  retire_rec_t  head record (pc, instr, rd, rd_data, rd_we, mem_addr, mem_data, mem_wrt, lane, seq[31:0])
- level_o  out  $clog2(Depth+1)  occupied entries
- overflow_o  out  1  sticky drop flag
- drop_cnt_o  out  16  dropped-record count, saturating

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low, rstn_i.
- Reset values: pointers 0, level_o 0, rec_valid_o 0, rec_o all-zero, overflow_o 0, drop_cnt_o 0, seq counter 0.
- Lane valid = update_i[k] | mem_wrt_i[k]. n = number of valid lanes this cycle, range 0..IssueWidth.
- Field masking at capture:
  - update_i=0: rd, rd_data and rd_we are stored as 0.
  - mem_wrt_i=0: mem_addr and mem_data are stored as 0.
  - lane field = k.
- Sequence numbers:
  - Each valid lane gets seq = seq_cnt + (rank among valid lanes, lane 0 first).
  - seq_cnt += n every cycle, whether or not the records are accepted. A gap in seq therefore marks a drop.
  - 32-bit counter, wraps modulo 2^32.
- Acceptance:
  - All-or-nothing per cycle: accept iff (Depth - level_o) >= n, using the registered level.
  - A same-cycle pop does not count as free space.
  - On accept, valid lanes are written to consecutive slots at wr_ptr in ascending lane order, and wr_ptr += n.
  - On reject, no lanes are written, overflow_o is set (sticky until reset), and drop_cnt_o += n, saturating at 0xFFFF.
- Output side:
  - rec_valid_o = (level_o != 0); rec_o = entry at rd_ptr.
  - Pop when rec_valid_o & rec_ready_i; rd_ptr += 1.
  - rec_o is stable while rec_valid_o & !rec_ready_i.
- Latency: a record captured in cycle t is visible on rec_o at t+1 at the earliest; there is no combinational bypass.
- Simultaneous push and pop: level_next = level + n_accepted - pop.
- Pointers are log2(Depth) bits and wrap naturally; level_o distinguishes full from empty.
- rec_ready_i while empty is ignored.
- Reset asserted mid-stream discards all buffered records immediately (asynchronously); no partial record is emitted after rstn_i rises.

Decomposition:
- riscv_pkg gains:
  - typedef retire_rec_t (packed struct of the fields above, lane width $clog2(IssueWidth), seq 32 bits)
  - constant TRACE_SEQ_W = 32
- One sub-module, retire_rec_fifo: multi-write (IssueWidth) / single-read FIFO with level and pointers.
- Lane compaction, seq assignment and drop accounting live in the top.

Test Plan:
- Reset, then both lanes valid in cycle 1 (lane0 pc=0x100 update rd=5 data=0xAA; lane1 pc=0x104 store addr=0x2000 data=0x55), rec_ready_i=1 -> cycle 2 emits seq0 lane0 pc 0x100 rd_we=1; cycle 3 emits seq1 lane1 mem_wrt=1 rd=0 rd_data=0.
- Only lane1 valid (update rd=7) -> one record, lane=1, seq=0; level_o peaks at 1.
- rec_ready_i=0 while both lanes are valid for 4 cycles (Depth=8) -> level_o=8, no overflow. Fifth cycle with both lanes valid -> overflow_o=1, drop_cnt_o=2, level_o stays 8. After ready, emitted seqs are 0..7, then the next accepted record carries seq 10.
- Level 7 with n=2 arriving while popping the same cycle -> rejected, drop_cnt_o+=2, level_o becomes 6.
- Continuous dual-lane retirement for 20 cycles with ready toggling 1,0 -> output stalls hold rec_o stable, ordering stays lane0-before-lane1, and seq is monotone with gaps exactly equal to drops.
- rstn_i low for 1 cycle while level_o=5 -> rec_valid_o=0 and level_o=0 immediately; next capture restarts at seq 0; overflow_o and drop_cnt_o are cleared.
